// File: rtl/led_counter_ctrl_if.sv
// Load handshake between a value requester and the LED counter controller.
interface led_counter_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             load_valid;
  logic [WIDTH-1:0] value;
  logic             load_ready;

  // Requester side: offers a value and holds it until accepted.
  modport master (output load_valid, output value, input load_ready);
  // Controller side: accepts when load_valid & load_ready.
  modport slave  (input load_valid, input value, output load_ready);
endinterface

// File: rtl/led_counter_ctrl.sv
// Sequencing controller for a free-running LED counter. Owns the count
// register and arbitrates load/start/stop/enable across IDLE, RUN, PAUSE and
// DONE. Supports wrap-at-limit and one-shot modes. led is a byte window of
// count.
module led_counter_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LED_LSB = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                mode_i,
  input  logic [WIDTH-1:0]    limit_i,
  led_counter_ctrl_if.slave   ld,
  output logic [WIDTH-1:0]    count_o,
  output logic [7:0]          led_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                wrap_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_ready;
  logic             accept;
  logic             at_limit;

  // Load is only offered outside RUN, so a load can never race an increment.
  assign accept   = ld.load_valid & load_ready;
  assign at_limit = (count_q == limit_i);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and datapath update; each branch lists its inputs in priority order.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A load wins over start in the same cycle.
        if (accept)       count_d = ld.value;
        else if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop_i) begin
          // Stop freezes the count even if enable is also high.
          state_d = S_PAUSE;
        end else if (enable_i && at_limit) begin
          if (!mode_i) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else if (enable_i) begin
          // Above the limit this rolls over naturally without a wrap pulse.
          count_d = count_q + 1'b1;
        end
      end
      S_PAUSE: begin
        // Stop dominates start, so both high keeps us paused.
        if (accept)                  count_d = ld.value;
        else if (start_i && !stop_i) state_d = S_RUN;
      end
      S_DONE: begin
        if (accept) begin
          count_d = ld.value;
          state_d = S_IDLE;
        end else if (start_i) begin
          count_d = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy_o     = (state_q == S_RUN);
    done_o     = (state_q == S_DONE);
    load_ready = (state_q != S_RUN);
  end

  assign ld.load_ready = load_ready;
  assign count_o       = count_q;
  assign led_o         = count_q[LED_LSB +: 8];
  assign wrap_o        = wrap_q;

endmodule
